// File: rtl/sdpb_pkg.sv
// Shared constants and elaboration helpers for the asymmetric line-buffer RAM.
package sdpb_pkg;

  localparam bit RDW_OLD = 1'b0;
  localparam bit RDW_NEW = 1'b1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit cfg_legal(input int wr_width, input int ratio, input int wr_depth);
    return ((ratio == 1) || (ratio == 2) || (ratio == 4)) && (wr_width > 0) &&
           ((wr_width % (8 * ratio)) == 0) && is_pow2(wr_depth);
  endfunction

endpackage

// File: rtl/sdpb_width_conv_if.sv
// Write/read bus of the width-converting line buffer; the master is the buffer's user.
interface sdpb_width_conv_if #(
  parameter int WR_WIDTH = 32,
  parameter int RATIO    = 2,
  parameter int WR_DEPTH = 64
);
  localparam int RD_WIDTH = WR_WIDTH / RATIO;
  localparam int WA       = sdpb_pkg::clog2(WR_DEPTH);
  localparam int RA       = WA + sdpb_pkg::clog2(RATIO);
  localparam int NBE      = WR_WIDTH / 8;

  logic                wr_en;
  logic [WA-1:0]       wr_addr;
  logic [WR_WIDTH-1:0] wr_data;
  logic [NBE-1:0]      wr_be;
  logic                rd_en;
  logic [RA-1:0]       rd_addr;
  logic                oce;
  logic [RD_WIDTH-1:0] rd_data;
  logic                rd_valid;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, oce,
    input  rd_data, rd_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, oce,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/sdpb_mem_core.sv
// Byte-enabled word array with a registered full-word read and a selectable
// read-during-write bypass. Neither the array nor the read register is reset.
module sdpb_mem_core #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 64,
  parameter bit RDW_NEW = 1'b0,
  localparam int AW  = sdpb_pkg::clog2(DEPTH),
  localparam int NBE = WIDTH / 8
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [NBE-1:0]   wr_be,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_word
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_word_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NBE; b++) begin
        if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  generate
    if (RDW_NEW == sdpb_pkg::RDW_NEW) begin : g_rdw_new
      // Write-first per byte: enabled lanes of a same-word write bypass the array.
      logic             hit;
      logic [WIDTH-1:0] merged;

      assign hit = wr_en && (wr_addr == rd_addr);

      for (genvar gi = 0; gi < NBE; gi++) begin : g_lane
        assign merged[gi*8 +: 8] = (hit && wr_be[gi]) ? wr_data[gi*8 +: 8]
                                                      : mem[rd_addr][gi*8 +: 8];
      end

      always_ff @(posedge clk) begin
        if (rd_en) rd_word_reg <= merged;
      end
    end else begin : g_rdw_old
      always_ff @(posedge clk) begin
        if (rd_en) rd_word_reg <= mem[rd_addr];
      end
    end
  endgenerate

  assign rd_word = rd_word_reg;

endmodule

// File: rtl/sdpb_width_conv.sv
// Width-converting simple dual-port line buffer: wide byte-enabled writes, narrow reads,
// optional oce-gated output stage and a read-valid pipeline flag.
module sdpb_width_conv #(
  parameter int WR_WIDTH = 32,
  parameter int RATIO    = 2,
  parameter int WR_DEPTH = 64,
  parameter bit OUT_REG  = 1'b0,
  parameter bit RDW_NEW  = 1'b0
) (
  input logic               clk,
  input logic               resetn,
  sdpb_width_conv_if.slave  bus
);

  localparam int RD_WIDTH = WR_WIDTH / RATIO;
  localparam int WA       = sdpb_pkg::clog2(WR_DEPTH);
  localparam int SW       = sdpb_pkg::clog2(RATIO);
  localparam int RA       = WA + SW;
  localparam int SEL_W    = (SW > 0) ? SW : 1;

  generate
    if (!sdpb_pkg::cfg_legal(WR_WIDTH, RATIO, WR_DEPTH)) begin : g_bad_cfg
      $error("sdpb_width_conv: illegal WR_WIDTH/RATIO/WR_DEPTH combination");
    end
  endgenerate

  logic [WA-1:0]       rd_word_addr;
  logic [SEL_W-1:0]    sel_next;
  logic [SEL_W-1:0]    sel_reg;
  logic [WR_WIDTH-1:0] rd_word;
  logic [RD_WIDTH-1:0] sub_word [RATIO];
  logic [RD_WIDTH-1:0] s1_data;
  logic                s1_valid_reg;
  logic                s1_loaded_reg;

  generate
    if (SW > 0) begin : g_split
      assign rd_word_addr = bus.rd_addr[RA-1:SW];
      assign sel_next     = bus.rd_addr[SW-1:0];
    end else begin : g_nosplit
      assign rd_word_addr = bus.rd_addr;
      assign sel_next     = '0;
    end

    for (genvar gi = 0; gi < RATIO; gi++) begin : g_sub
      assign sub_word[gi] = rd_word[gi*RD_WIDTH +: RD_WIDTH];
    end
  endgenerate

  sdpb_mem_core #(
    .WIDTH   (WR_WIDTH),
    .DEPTH   (WR_DEPTH),
    .RDW_NEW (RDW_NEW)
  ) u_core (
    .clk     (clk),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .wr_be   (bus.wr_be),
    .rd_en   (bus.rd_en),
    .rd_addr (rd_word_addr),
    .rd_word (rd_word)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_reg  <= 1'b0;
      s1_loaded_reg <= 1'b0;
      sel_reg       <= '0;
    end else begin
      s1_valid_reg <= bus.rd_en;
      if (bus.rd_en) begin
        s1_loaded_reg <= 1'b1;
        sel_reg       <= sel_next;
      end
    end
  end

  // The RAM read register keeps no reset; zero the output until a read has landed.
  assign s1_data = s1_loaded_reg ? sub_word[sel_reg] : '0;

  generate
    if (OUT_REG) begin : g_out_reg
      logic [RD_WIDTH-1:0] s2_data_reg;
      logic                s2_valid_reg;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          s2_data_reg  <= '0;
          s2_valid_reg <= 1'b0;
        end else if (bus.oce) begin
          s2_data_reg  <= s1_data;
          s2_valid_reg <= s1_valid_reg;
        end
      end

      assign bus.rd_data  = s2_data_reg;
      assign bus.rd_valid = s2_valid_reg;
    end else begin : g_no_out_reg
      logic unused_oce;
      assign unused_oce   = bus.oce;
      assign bus.rd_data  = s1_data;
      assign bus.rd_valid = s1_valid_reg;
    end
  endgenerate

endmodule

// File: tb/tb_sdpb_width_conv.sv
// Directed bench: one stimulus stream drives three configurations
// (latency 1 old-data, latency 1 new-data, latency 2 old-data).
module tb_sdpb_width_conv;

  logic        clk;
  logic        resetn;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_en;
  logic [6:0]  rd_addr;
  logic        oce;

  int n_checks;
  int n_fail;

  sdpb_width_conv_if #(.WR_WIDTH(32), .RATIO(2), .WR_DEPTH(64)) b0 ();
  sdpb_width_conv_if #(.WR_WIDTH(32), .RATIO(2), .WR_DEPTH(64)) b1 ();
  sdpb_width_conv_if #(.WR_WIDTH(32), .RATIO(2), .WR_DEPTH(64)) b2 ();

  assign b0.wr_en = wr_en; assign b0.wr_addr = wr_addr; assign b0.wr_data = wr_data;
  assign b0.wr_be = wr_be; assign b0.rd_en = rd_en; assign b0.rd_addr = rd_addr; assign b0.oce = oce;
  assign b1.wr_en = wr_en; assign b1.wr_addr = wr_addr; assign b1.wr_data = wr_data;
  assign b1.wr_be = wr_be; assign b1.rd_en = rd_en; assign b1.rd_addr = rd_addr; assign b1.oce = oce;
  assign b2.wr_en = wr_en; assign b2.wr_addr = wr_addr; assign b2.wr_data = wr_data;
  assign b2.wr_be = wr_be; assign b2.rd_en = rd_en; assign b2.rd_addr = rd_addr; assign b2.oce = oce;

  sdpb_width_conv #(.WR_WIDTH(32), .RATIO(2), .WR_DEPTH(64), .OUT_REG(1'b0), .RDW_NEW(1'b0))
    dut_old (.clk(clk), .resetn(resetn), .bus(b0));
  sdpb_width_conv #(.WR_WIDTH(32), .RATIO(2), .WR_DEPTH(64), .OUT_REG(1'b0), .RDW_NEW(1'b1))
    dut_new (.clk(clk), .resetn(resetn), .bus(b1));
  sdpb_width_conv #(.WR_WIDTH(32), .RATIO(2), .WR_DEPTH(64), .OUT_REG(1'b1), .RDW_NEW(1'b0))
    dut_reg (.clk(clk), .resetn(resetn), .bus(b2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic [5:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        re;
    logic [6:0]  ra;
    bit          chk_valid;
    bit          chk_data;
    logic [15:0] exp_data;
    logic        exp_valid;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [5:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic re, input logic [6:0] ra);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be; rd_en = re; rd_addr = ra;
  endtask

  task automatic idle();
    drive(1'b0, 6'd0, 32'h0, 4'h0, 1'b0, 7'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //            we  wa     wd            be    re  ra      cv cd  data      valid
    vecs[0]  = '{1'b0, 6'd0,  32'h0,        4'h0, 1'b1, 7'd20,  1, 0, 16'h0,    1'b1};
    vecs[1]  = '{1'b1, 6'd5,  32'hDEADBEEF, 4'hF, 1'b0, 7'd0,   1, 0, 16'h0,    1'b0};
    vecs[2]  = '{1'b0, 6'd0,  32'h0,        4'h0, 1'b1, 7'd10,  1, 1, 16'hBEEF, 1'b1};
    vecs[3]  = '{1'b0, 6'd0,  32'h0,        4'h0, 1'b1, 7'd11,  1, 1, 16'hDEAD, 1'b1};
    vecs[4]  = '{1'b0, 6'd0,  32'h0,        4'h0, 1'b0, 7'd0,   1, 1, 16'hDEAD, 1'b0};
    vecs[5]  = '{1'b1, 6'd3,  32'h11223344, 4'hF, 1'b0, 7'd0,   1, 0, 16'h0,    1'b0};
    vecs[6]  = '{1'b1, 6'd3,  32'hAABBCCDD, 4'h5, 1'b0, 7'd0,   1, 0, 16'h0,    1'b0};
    vecs[7]  = '{1'b0, 6'd0,  32'h0,        4'h0, 1'b1, 7'd6,   1, 1, 16'h33DD, 1'b1};
    vecs[8]  = '{1'b0, 6'd0,  32'h0,        4'h0, 1'b1, 7'd7,   1, 1, 16'h11BB, 1'b1};
    vecs[9]  = '{1'b1, 6'd63, 32'hCAFEF00D, 4'hF, 1'b0, 7'd0,   1, 0, 16'h0,    1'b0};
    vecs[10] = '{1'b0, 6'd0,  32'h0,        4'h0, 1'b1, 7'd127, 1, 1, 16'hCAFE, 1'b1};
    vecs[11] = '{1'b1, 6'd0,  32'h55667788, 4'hF, 1'b1, 7'd126, 1, 1, 16'hF00D, 1'b1};
    vecs[12] = '{1'b0, 6'd0,  32'h0,        4'h0, 1'b1, 7'd0,   1, 1, 16'h7788, 1'b1};
    vecs[13] = '{1'b0, 6'd0,  32'h0,        4'h0, 1'b1, 7'd1,   1, 1, 16'h5566, 1'b1};

    // Reset held with a read request pending.
    resetn = 1'b0;
    oce    = 1'b1;
    drive(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 7'd0);
    repeat (3) tick();
    check("reset d0 data",  32'(b0.rd_data),  32'h0);
    check("reset d0 valid", 32'(b0.rd_valid), 32'h0);
    check("reset d2 data",  32'(b2.rd_data),  32'h0);
    check("reset d2 valid", 32'(b2.rd_valid), 32'h0);
    resetn = 1'b1;
    idle();
    tick();

    // Table vectors, latency-1 configurations; non-colliding rows agree for both RDW modes.
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].be, vecs[i].re, vecs[i].ra);
      tick();
      $display("vec %0d: we=%0b wa=%0d wd=0x%08h be=%h re=%0b ra=%0d -> d0=0x%04h/%0b d1=0x%04h/%0b",
               i, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].be, vecs[i].re, vecs[i].ra,
               b0.rd_data, b0.rd_valid, b1.rd_data, b1.rd_valid);
      if (vecs[i].chk_valid) begin
        check($sformatf("vec%0d d0 valid", i), 32'(b0.rd_valid), 32'(vecs[i].exp_valid));
        check($sformatf("vec%0d d1 valid", i), 32'(b1.rd_valid), 32'(vecs[i].exp_valid));
      end
      if (vecs[i].chk_data) begin
        check($sformatf("vec%0d d0 data", i), 32'(b0.rd_data), 32'(vecs[i].exp_data));
        check($sformatf("vec%0d d1 data", i), 32'(b1.rd_data), 32'(vecs[i].exp_data));
      end
    end

    // Read-during-write collisions on word 2.
    drive(1'b1, 6'd2, 32'h0, 4'hF, 1'b0, 7'd0);
    tick();
    drive(1'b1, 6'd2, 32'h12345678, 4'hF, 1'b1, 7'd4);
    tick();
    $display("rdw full: d0=0x%04h d1=0x%04h", b0.rd_data, b1.rd_data);
    check("rdw full old", 32'(b0.rd_data), 32'h0000);
    check("rdw full new", 32'(b1.rd_data), 32'h5678);
    drive(1'b1, 6'd2, 32'hAAAAAAAA, 4'h1, 1'b1, 7'd4);
    tick();
    $display("rdw partial: d0=0x%04h d1=0x%04h", b0.rd_data, b1.rd_data);
    check("rdw part old", 32'(b0.rd_data), 32'h5678);
    check("rdw part new", 32'(b1.rd_data), 32'h56AA);
    drive(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 7'd4);
    tick();
    check("rdw after d0", 32'(b0.rd_data), 32'h56AA);
    check("rdw after d1", 32'(b1.rd_data), 32'h56AA);

    // Output stage: latency 2 with oce high, then hold while oce is low.
    idle();
    oce = 1'b1;
    repeat (2) tick();
    drive(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 7'd10);
    tick();
    check("oreg lat1 valid", 32'(b2.rd_valid), 32'h0);
    idle();
    tick();
    $display("oreg read 10: d2=0x%04h/%0b", b2.rd_data, b2.rd_valid);
    check("oreg lat2 data",  32'(b2.rd_data),  32'hBEEF);
    check("oreg lat2 valid", 32'(b2.rd_valid), 32'h1);
    oce = 1'b0;
    drive(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 7'd11);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("oreg hold%0d data", c), 32'(b2.rd_data), 32'hBEEF);
    end
    oce = 1'b1;
    idle();
    tick();
    $display("oreg oce back: d2=0x%04h/%0b", b2.rd_data, b2.rd_valid);
    check("oreg resume data",  32'(b2.rd_data),  32'hDEAD);
    check("oreg resume valid", 32'(b2.rd_valid), 32'h1);
    tick();
    check("oreg drain valid", 32'(b2.rd_valid), 32'h0);
    check("oreg drain data",  32'(b2.rd_data),  32'hDEAD);

    // Reset one cycle after a read on the registered configuration drops that read.
    drive(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 7'd127);
    tick();
    idle();
    resetn = 1'b0;
    tick();
    check("rst mid valid", 32'(b2.rd_valid), 32'h0);
    check("rst mid data",  32'(b2.rd_data),  32'h0);
    resetn = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      check($sformatf("rst after%0d valid", c), 32'(b2.rd_valid), 32'h0);
    end
    check("rst after d0 data", 32'(b0.rd_data), 32'h0);
    drive(1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 7'd127);
    tick();
    idle();
    tick();
    $display("post-reset read 127: d2=0x%04h/%0b", b2.rd_data, b2.rd_valid);
    check("rst reread data",  32'(b2.rd_data),  32'hCAFE);
    check("rst reread valid", 32'(b2.rd_valid), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
